// File: rtl/image_mem_pkg.sv
// Shared constants and types for the image bitmap memory and its arbiter.
// Bitmap is 48x48 pixels, 3 bytes per pixel in RGB order, byte addressed.
// Owner and arbiter state encodings are shared with anything tagging reads.
package image_mem_pkg;

  localparam int IMG_W        = 48;
  localparam int IMG_H        = 48;
  localparam int BYTES_PER_PX = 3;
  localparam int IMG_BYTES    = IMG_W * IMG_H * BYTES_PER_PX;
  // Default byte-address width; 6912 bytes fit in 13 bits.
  localparam int IMG_ADDR_W   = 13;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_UI   = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_NORMAL   = 1'b0,
    ARB_FORCE_UI = 1'b1
  } arb_state_e;

endpackage

// File: rtl/image_mem_arbiter.sv
// Fixed-priority read arbiter (display over UI) for the image memory, with a UI starvation guard.
// Latency: grant/address same cycle as request; tagged read data and rvalid two cycles later.
// Backpressure: display sees disp_stall when a forced UI slot wins; UI holds its request until ui_gnt; returns are never stalled.
module image_mem_arbiter
  import image_mem_pkg::*;
#(
  parameter int ADDR_W     = IMG_ADDR_W,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_stall,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              ui_req,
  input  logic [ADDR_W-1:0] ui_addr,
  output logic              ui_gnt,
  output logic              ui_rvalid,
  output logic [DATA_W-1:0] ui_rdata,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_nxt;
  logic [7:0] starve_cnt, starve_nxt;
  logic       tag_issued;
  owner_e     tag_owner;

  // Grant selection and memory port drive; everything is held low while in reset.
  always_comb begin
    disp_gnt   = 1'b0;
    ui_gnt     = 1'b0;
    disp_stall = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    if (!rst) begin
      if (state == ARB_FORCE_UI) begin
        ui_gnt     = ui_req;
        disp_stall = disp_req;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end else begin
        ui_gnt = ui_req;
      end
      mem_rd = disp_gnt | ui_gnt;
      if (disp_gnt) begin
        mem_addr = disp_addr;
      end else if (ui_gnt) begin
        mem_addr = ui_addr;
      end
    end
  end

  // Starvation counting and the one-cycle forced UI slot once the limit is hit.
  always_comb begin
    starve_nxt = 8'd0;
    state_nxt  = ARB_NORMAL;
    if (ui_req && !ui_gnt) begin
      starve_nxt = (starve_cnt == 8'hFF) ? 8'hFF : starve_cnt + 8'd1;
    end
    if ((state == ARB_NORMAL) && (starve_nxt == 8'(STARVE_MAX))) begin
      state_nxt = ARB_FORCE_UI;
    end
  end

  // Arbiter state, starvation counter and the owner tag of the read just issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_NORMAL;
      starve_cnt <= 8'd0;
      tag_issued <= 1'b0;
      tag_owner  <= OWN_DISP;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      tag_issued <= mem_rd;
      tag_owner  <= ui_gnt ? OWN_UI : OWN_DISP;
    end
  end

  // Route the returning memory byte to its owner; the other side keeps its last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_rvalid <= 1'b0;
      ui_rvalid   <= 1'b0;
      disp_rdata  <= '0;
      ui_rdata    <= '0;
    end else begin
      disp_rvalid <= tag_issued && (tag_owner == OWN_DISP);
      ui_rvalid   <= tag_issued && (tag_owner == OWN_UI);
      if (tag_issued && (tag_owner == OWN_DISP)) begin
        disp_rdata <= mem_rdata;
      end
      if (tag_issued && (tag_owner == OWN_UI)) begin
        ui_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Bench for image_mem_arbiter: directed scenarios with literal expectations, then random traffic.
// A behavioural model (denied-cycle count plus a queue of pending returns) is compared every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_image_mem_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int SM = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt, disp_stall, disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          ui_req = 1'b0;
  logic [AW-1:0] ui_addr = '0;
  logic          ui_gnt, ui_rvalid;
  logic [DW-1:0] ui_rdata;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  logic [7:0] mem [0:8191];

  int checks = 0;
  int errors = 0;

  image_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_stall(disp_stall), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .ui_req(ui_req), .ui_addr(ui_addr), .ui_gnt(ui_gnt),
    .ui_rvalid(ui_rvalid), .ui_rdata(ui_rdata),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address presented appears one cycle later.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         vis;
    bit         ui;
    logic [7:0] d;
  } ret_t;

  ret_t       pend[$];
  ret_t       r;
  int         cyc = 0;
  int         denied = 0;
  logic       m_dv = 1'b0, m_uv = 1'b0;
  logic [7:0] m_dd = 8'h00, m_ud = 8'h00;
  bit         f, eg_d, eg_u, est;
  logic [AW-1:0] ea;

  // Compare every cycle, then advance the model to what the next edge must produce.
  always @(negedge clk) begin
    // UI is forced once it has been denied STARVE_MAX cycles in a row.
    f    = (denied == SM);
    eg_d = 1'b0;
    eg_u = 1'b0;
    est  = 1'b0;
    if (!rst) begin
      if (f) begin
        eg_u = ui_req;
        est  = disp_req;
      end else begin
        eg_d = disp_req;
        eg_u = ui_req && !disp_req;
      end
    end
    ea = eg_d ? disp_addr : (eg_u ? ui_addr : '0);

    chk("disp_gnt",    disp_gnt,    eg_d);
    chk("ui_gnt",      ui_gnt,      eg_u);
    chk("disp_stall",  disp_stall,  est);
    chk("mem_rd",      mem_rd,      eg_d | eg_u);
    chk("mem_addr",    mem_addr,    ea);
    chk("disp_rvalid", disp_rvalid, m_dv);
    chk("disp_rdata",  disp_rdata,  m_dd);
    chk("ui_rvalid",   ui_rvalid,   m_uv);
    chk("ui_rdata",    ui_rdata,    m_ud);

    if (rst) begin
      pend.delete();
      denied = 0;
      m_dv = 1'b0; m_uv = 1'b0; m_dd = 8'h00; m_ud = 8'h00;
    end else begin
      m_dv = 1'b0;
      m_uv = 1'b0;
      while (pend.size() > 0 && pend[0].vis == cyc + 1) begin
        r = pend.pop_front();
        if (r.ui) begin m_uv = 1'b1; m_ud = r.d; end
        else      begin m_dv = 1'b1; m_dd = r.d; end
      end
      if (eg_d || eg_u) pend.push_back('{vis: cyc + 2, ui: eg_u, d: mem[ea]});
      if (ui_req && !eg_u) denied = (denied < 255) ? denied + 1 : 255;
      else denied = 0;
    end
    cyc++;
  end

  // One cycle of stimulus; returns at the falling edge so the caller can sample.
  task automatic step(input int rs, input int dr, input int da, input int ur, input int ua);
    @(posedge clk);
    #1;
    rst       = rs[0];
    disp_req  = dr[0];
    disp_addr = da[AW-1:0];
    ui_req    = ur[0];
    ui_addr   = ua[AW-1:0];
    @(negedge clk);
  endtask

  int first, second, ngnt, nst, bad, uaddr, upend, ugot, rr, dprob;
  logic [7:0] exp_data [4];
  int         exp_own  [4];
  int         il_dr [6], il_da [6], il_ur [6], il_ua [6];

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 37 + 5) ^ (i >> 5));
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    mem[13'h1AFF] = 8'hA5;
    mem[4] = 8'h01; mem[5] = 8'h02; mem[6] = 8'h03; mem[7] = 8'h04;

    // Reset held two cycles with both requests high: everything low.
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 3, 1, 'h100);
      chk("rst_disp_gnt", disp_gnt, 0);
      chk("rst_ui_gnt",   ui_gnt,   0);
      chk("rst_mem_rd",   mem_rd,   0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rvalid",   {disp_rvalid, ui_rvalid}, 0);
    end
    step(0, 1, 3, 1, 'h100);
    chk("post_rst_disp_first", disp_gnt, 1);
    // Read issued just before reset must never return.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_issue_no_rvalid", disp_rvalid, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_issue_no_rvalid2", disp_rvalid, 0);

    // Display-only stream.
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
    for (int k = 0; k < 6; k++) begin
      step(0, (k < 3) ? 1 : 0, k, 0, 0);
      chk("stream_stall", disp_stall, 0);
      if (k >= 2 && k < 5) begin
        chk("stream_rvalid", disp_rvalid, 1);
        chk("stream_rdata",  disp_rdata,  exp_data[k-2]);
      end else begin
        chk("stream_rvalid_idle", disp_rvalid, 0);
      end
    end

    // UI alone at the last bitmap byte.
    step(0, 0, 0, 1, 'h1AFF);
    chk("ui_alone_gnt",  ui_gnt,   1);
    chk("ui_alone_addr", mem_addr, 'h1AFF);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ui_alone_rvalid", ui_rvalid,   1);
    chk("ui_alone_rdata",  ui_rdata,    'hA5);
    chk("ui_alone_disp_hold", disp_rdata, 'h33);
    chk("ui_alone_disp_rvalid", disp_rvalid, 0);

    // Starvation: both requesting continuously.
    first = 0; second = 0; ngnt = 0; nst = 0; bad = 0; uaddr = 'h300;
    for (int k = 1; k <= 32; k++) begin
      step(0, 1, k, 1, uaddr);
      if (ui_gnt) begin
        ngnt++;
        if (ngnt == 1) first = k; else if (ngnt == 2) second = k;
        uaddr++;
      end
      if (disp_stall) begin
        nst++;
        if (!ui_gnt) bad++;
      end
    end
    chk("starve_first",  first,  16);
    chk("starve_second", second, 32);
    chk("starve_ngnt",   ngnt,   2);
    chk("starve_nstall", nst,    2);
    chk("starve_stall_alone", bad, 0);

    // Alternating owners: returns in issue order, no bubbles.
    il_dr = '{1, 0, 1, 0, 0, 0}; il_da = '{4, 0, 6, 0, 0, 0};
    il_ur = '{0, 1, 0, 1, 0, 0}; il_ua = '{0, 5, 0, 7, 0, 0};
    exp_own = '{0, 1, 0, 1};
    exp_data[0] = 8'h01; exp_data[1] = 8'h02; exp_data[2] = 8'h03; exp_data[3] = 8'h04;
    for (int k = 0; k < 6; k++) begin
      step(0, il_dr[k], il_da[k], il_ur[k], il_ua[k]);
      if (k >= 2) begin
        if (exp_own[k-2] == 0) begin
          chk("il_disp_rvalid", disp_rvalid, 1);
          chk("il_disp_rdata",  disp_rdata,  exp_data[k-2]);
          chk("il_ui_quiet",    ui_rvalid,   0);
        end else begin
          chk("il_ui_rvalid",  ui_rvalid,   1);
          chk("il_ui_rdata",   ui_rdata,    exp_data[k-2]);
          chk("il_disp_quiet", disp_rvalid, 0);
        end
      end
    end

    // Reset while the forced UI slot is due, then starvation must restart from zero.
    for (int k = 1; k <= 15; k++) step(0, 1, k, 1, 'h400);
    step(1, 1, 0, 1, 'h400);
    chk("force_rst_ui_gnt", ui_gnt, 0);
    first = 0;
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, k, 1, 'h400);
      if (k == 1) chk("force_rst_disp_first", disp_gnt, 1);
      if (ui_gnt && first == 0) first = k;
    end
    chk("force_rst_restart", first, 16);

    // Reset in the cycle after a UI grant.
    step(0, 0, 0, 1, 'h50);
    chk("mid_rst_ui_gnt", ui_gnt, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_rst_no_rvalid", ui_rvalid, 0);
    step(0, 1, 9, 1, 'h51);
    chk("mid_rst_no_rvalid2", ui_rvalid, 0);
    chk("mid_rst_normal", disp_gnt, 1);

    // Random traffic with phases of heavy display load and occasional resets.
    upend = 0; ugot = 0; uaddr = 0;
    for (int i = 0; i < 3000; i++) begin
      rr    = ($urandom_range(0, 199) == 0) ? 1 : 0;
      dprob = ((i % 1000) < 500) ? 5 : 10;
      if (!upend || ugot || rr) begin
        upend = ($urandom_range(0, 9) < 6) ? 1 : 0;
        uaddr = $urandom_range(0, 8191);
      end
      step(rr, ($urandom_range(0, 9) < dprob) ? 1 : 0, $urandom_range(0, 8191), upend, uaddr);
      ugot = int'(ui_gnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_mem_arbiter.md
# image_mem_arbiter

Shares the single synchronous-read image bitmap memory (byte-wide, 3 bytes per pixel, RGB order) between two readers: the display pixel fetch path (latency-critical, high priority) and the UI/POS logic (background reads, e.g. icon lookup and checksum). Sits between both requesters and the memory read port. Uses fixed priority with a starvation guard, and returns read data tagged to its owner with a fixed 2-cycle latency.

## Interface
Parameters:
- ADDR_W, 13, memory byte-address width; 3*48*48 = 6912 bytes fits.
- DATA_W, 8, memory data width.
- STARVE_MAX, 15, consecutive denied UI cycles before the UI read is forced through; legal range 1..255.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display byte address; sampled when disp_gnt=1.
- disp_gnt  out  1  display request accepted this cycle (combinational).
- disp_stall  out  1  disp_req was denied this cycle (combinational).
- disp_rvalid  out  1  disp_rdata valid (registered).
- disp_rdata  out  DATA_W  display read data (registered).
- ui_req  in  1  UI read request; held with ui_addr stable until ui_gnt.
- ui_addr  in  ADDR_W  UI byte address.
- ui_gnt  out  1  UI request accepted this cycle (combinational).
- ui_rvalid  out  1  ui_rdata valid (registered).
- ui_rdata  out  DATA_W  UI read data (registered).
- mem_rd  out  1  memory read strobe (combinational).
- mem_addr  out  ADDR_W  memory address (combinational; 0 when mem_rd=0).
- mem_rdata  in  DATA_W  memory data, valid one cycle after the mem_rd cycle.

## Operation
- FSM with two states:
  - NORMAL: display wins.
  - FORCE_UI: UI wins for exactly one cycle.
- NORMAL:
  - disp_req=1 → disp_gnt=1, mem_addr=disp_addr.
  - else ui_req=1 → ui_gnt=1, mem_addr=ui_addr.
  - mem_rd = disp_gnt | ui_gnt. At most one grant per cycle.
- Starvation counter starve_cnt, 8 bits:
  - Increments each cycle with ui_req=1 and ui_gnt=0, saturating at 255.
  - Clears on ui_gnt=1 or ui_req=0.
  - When starve_cnt reaches STARVE_MAX at a clock edge, next state is FORCE_UI.
- FORCE_UI:
  - ui_gnt=ui_req; disp_gnt=0.
  - disp_stall=disp_req.
  - Returns to NORMAL the next cycle unconditionally.
  - If ui_req dropped meanwhile, it is a no-op cycle with no grant; the display is still stalled.
- disp_stall in NORMAL is always 0.
- Owner tag: 2-bit register {issued, owner} captures the granting side each cycle.
- mem_rdata is registered into the owner's rdata in the cycle after issue, and the owner's rvalid is pulsed. The non-owner's rdata holds its previous value.
- Requesters need no ready signal on the return path; returns are never back-pressured.

## Timing
- Grant and memory address are same-cycle as the request (cycle N).
- mem_rdata is valid at N+1. rvalid/rdata are registered at the N+1 edge and visible during N+2.
- Read latency is 2 cycles. Throughput is 1 read per cycle total.
- Back-to-back grants to alternating owners return in issue order, one per cycle, with no bubbles.
- Reset (sync, rst=1 at an edge):
  - state=NORMAL, starve_cnt=0, tag cleared.
  - disp_rvalid=ui_rvalid=0, disp_rdata=ui_rdata=0.
- Combinational outputs during rst=1 are forced low: gnt, stall, mem_rd, and mem_addr=0.
- Reset mid-operation: a read issued in the cycle before reset never produces rvalid.
- Reset in FORCE_UI returns to NORMAL.

## Structure
- Shared package `image_mem_pkg`:
  - IMG_W=48, IMG_H=48, BYTES_PER_PX=3, IMG_BYTES=6912.
  - ADDR_W default.
  - Owner enum {OWN_DISP, OWN_UI}.
  - Arbiter state enum {ARB_NORMAL, ARB_FORCE_UI}.
- Single module. No sub-module; the starvation counter and return register are inline.

## Test plan
- Reset: hold rst 2 cycles with both reqs high → all outputs 0. After release, disp granted first cycle; rvalid never pulses for pre-reset issues.
- Display-only stream: disp_addr 0,1,2 on consecutive cycles with memory bytes 0x11,0x22,0x33 → disp_rvalid high for 3 cycles starting 2 cycles later, data 0x11,0x22,0x33, disp_stall always 0.
- UI alone: ui_req with addr 0x1AFF, memory 0xA5 → ui_gnt same cycle, ui_rvalid=1 with 0xA5 at +2; disp_rdata unchanged.
- Starvation: disp_req and ui_req both continuously high, STARVE_MAX=15 → ui_gnt on the 16th cycle, disp_stall=1 that single cycle, pattern repeats every 16 cycles.
- Interleave: alternating disp/ui grants with memory values 0x01..0x04 → returns routed to the correct owner in issue order, no lost or duplicated rvalid.
- Reset mid-read: assert rst in the cycle after a ui grant → no ui_rvalid, starve_cnt=0, FSM in NORMAL.
